shift_seq_ctrl: RTL and testbench
=================================

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
- REQ-001: Parameter LUI_AMT, default 16: shift distance applied for the lui operation.
- REQ-002: clk  input  1  rising-edge clock; the block has one clock domain.
- REQ-003: reset  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
- REQ-004: start  input  1  request from the main control unit, sampled only in IDLE.
- REQ-005: op  input  3  operation: 000 sll, 001 srl, 010 sra, 011 sllv, 100 srlv, 101 srav, 110 lui, 111 illegal.
- REQ-006: shamt  input  5  immediate shift amount, IR[10:6].
- REQ-007: rs_amt  input  5  variable shift amount, A[4:0].
- REQ-008: EntryCtrl  output  2  select for the shift-register entry mux: 00 IR[15:0], 01 B, 10 A.
- REQ-009: ShiftCtrl  output  3  shift-register command: 000 hold, 001 load, 010 left n, 011 right logical n, 100 right arithmetic n.
- REQ-010: ShiftN  output  5  shift distance n for the shift register.
- REQ-011: busy  output  1  high while the FSM is in LOAD, SHIFT or DONE.
- REQ-012: done  output  1  one-cycle pulse: the shift-register result is valid.
- REQ-013: err  output  1  one-cycle pulse: the request used the illegal op.

Function
- REQ-014: The FSM SHALL have four states: IDLE, LOAD, SHIFT and DONE. All outputs SHALL be Moore-decoded from the state and the registers latched at acceptance.
- REQ-015: In IDLE, start=1 with a legal op SHALL, on that edge, latch:
  - the shift command: sll/sllv/lui -> 010; srl/srlv -> 011; sra/srav -> 100;
  - the amount: shamt for ops 000-010, rs_amt for ops 011-101, LUI_AMT[4:0] for lui;
  - the entry select: 00 for lui, 01 otherwise.
  The FSM then SHALL go to LOAD.
- REQ-016: In IDLE, start=1 with op=111 SHALL pulse err for the next cycle only. The FSM SHALL stay in IDLE and latch nothing.
- REQ-017: LOAD SHALL drive ShiftCtrl=001 with EntryCtrl set to the latched select. It then SHALL go to SHIFT, or directly to DONE if the latched amount is 0.
- REQ-018: SHIFT SHALL drive ShiftCtrl set to the latched command and ShiftN set to the latched amount for exactly one cycle, then go to DONE.
- REQ-019: DONE SHALL drive ShiftCtrl=000 and done=1 for exactly one cycle, then go to IDLE.
- REQ-020: Latency: start accepted at edge k gives LOAD in cycle k+1, SHIFT in k+2, and done in k+3. A zero amount gives done in k+2.
- REQ-021: start SHALL be ignored while busy=1. op, shamt and rs_amt changes after acceptance SHALL have no effect.
- REQ-022: A start asserted in the DONE cycle SHALL be ignored. A new request is accepted no earlier than the first IDLE cycle.
- REQ-023: Outside LOAD, EntryCtrl SHALL be 00. Outside SHIFT, ShiftN SHALL be 0.
- REQ-024: In IDLE, ShiftCtrl SHALL be 000, and busy and done SHALL be 0.
- REQ-025: EntryCtrl=10 and ShiftCtrl codes 101-111 are reserved and SHALL never be driven.

Reset
- REQ-026: reset=0 SHALL force the FSM to IDLE asynchronously. It SHALL also set all latched registers and all outputs to 0: EntryCtrl=00, ShiftCtrl=000, ShiftN=0, busy=0, done=0, err=0.
- REQ-027: Reset asserted in any state mid-operation SHALL abort the sequence without emitting done.
- REQ-028: The first request after reset deassertion SHALL be accepted normally.

Verification
- REQ-029: The bench SHALL cover these directed scenarios:
  - sll: op=000, shamt=3 -> LOAD (EntryCtrl=01, ShiftCtrl=001); then SHIFT (ShiftCtrl=010, ShiftN=3); then done pulse at k+3.
  - srav: op=101, shamt=7, rs_amt=31 -> SHIFT cycle shows ShiftCtrl=100, ShiftN=31; shamt is ignored.
  - lui: op=110 -> LOAD shows EntryCtrl=00; SHIFT shows ShiftCtrl=010, ShiftN=16.
  - Zero amount: op=001, shamt=0 -> LOAD then DONE; done at k+2; no SHIFT cycle.
  - Busy protection: op=111 in IDLE -> single err pulse, busy stays 0. start held high through a sll sequence -> exactly one done per accepted request, with a 1-cycle IDLE gap before re-acceptance.
  - Reset abort: reset=0 during SHIFT -> all outputs 0 in the same cycle, no done; the next start completes correctly.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// Sequencer for a shared shift register: accepts a shift request, steers the entry mux,
// loads the operand, issues one shift command, then pulses done.
//
//   state | meaning
//   IDLE  | waiting for start; request fields latched on acceptance
//   LOAD  | load shift register from entry mux (latched select)
//   SHIFT | apply latched command with latched distance for one cycle
//   DONE  | result valid, done pulse; start ignored here
module shift_seq_ctrl #(
  parameter int LUI_AMT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [4:0] shamt,
  input  logic [4:0] rs_amt,
  output logic [1:0] EntryCtrl,
  output logic [2:0] ShiftCtrl,
  output logic [4:0] ShiftN,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] LUI_FULL  = LUI_AMT;
  localparam logic [4:0]  LUI_SHAMT = LUI_FULL[4:0];

  localparam logic [2:0] CMD_HOLD  = 3'b000;
  localparam logic [2:0] CMD_LOAD  = 3'b001;
  localparam logic [2:0] CMD_LEFT  = 3'b010;
  localparam logic [2:0] CMD_RLOG  = 3'b011;
  localparam logic [2:0] CMD_RARI  = 3'b100;

  localparam logic [1:0] SEL_IR = 2'b00;
  localparam logic [1:0] SEL_B  = 2'b01;

  state_t     state, state_nxt;
  logic [2:0] cmd_q, cmd_nxt;
  logic [4:0] amt_q, amt_nxt;
  logic [1:0] sel_q, sel_nxt;
  logic       err_q, err_nxt;
  logic       req_legal, req_illegal;

  assign req_legal   = (state == IDLE) && start && (op != 3'b111);
  assign req_illegal = (state == IDLE) && start && (op == 3'b111);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cmd_q <= '0;
      amt_q <= '0;
      sel_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cmd_q <= cmd_nxt;
      amt_q <= amt_nxt;
      sel_q <= sel_nxt;
      err_q <= err_nxt;
    end
  end

  // Request decode; registers only move on a legal acceptance.
  always_comb begin
    cmd_nxt = cmd_q;
    amt_nxt = amt_q;
    sel_nxt = sel_q;
    err_nxt = req_illegal;
    if (req_legal) begin
      case (op)
        3'b000, 3'b011, 3'b110: cmd_nxt = CMD_LEFT;
        3'b001, 3'b100:         cmd_nxt = CMD_RLOG;
        default:                cmd_nxt = CMD_RARI;
      endcase
      case (op)
        3'b000, 3'b001, 3'b010: amt_nxt = shamt;
        3'b110:                 amt_nxt = LUI_SHAMT;
        default:                amt_nxt = rs_amt;
      endcase
      sel_nxt = (op == 3'b110) ? SEL_IR : SEL_B;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_legal) state_nxt = LOAD;
      LOAD:    state_nxt = (amt_q == 5'd0) ? DONE : SHIFT;
      SHIFT:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    EntryCtrl = SEL_IR;
    ShiftCtrl = CMD_HOLD;
    ShiftN    = 5'd0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = err_q;
    case (state)
      LOAD: begin
        EntryCtrl = sel_q;
        ShiftCtrl = CMD_LOAD;
        busy      = 1'b1;
      end
      SHIFT: begin
        ShiftCtrl = cmd_q;
        ShiftN    = amt_q;
        busy      = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: directed vector table, reset-abort sequence, and
// randomized traffic against a request-level expected-cycle queue model.
module tb_shift_seq_ctrl;

  typedef struct packed {
    logic [1:0] entry;
    logic [2:0] ctrl;
    logic [4:0] n;
    logic       busy;
    logic       done;
    logic       err;
  } out_t;

  typedef struct {
    logic       st;
    logic [2:0] op;
    logic [4:0] sh;
    logic [4:0] rs;
    out_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = '0;
  logic [4:0] shamt = '0;
  logic [4:0] rs_amt = '0;
  logic [1:0] EntryCtrl;
  logic [2:0] ShiftCtrl;
  logic [4:0] ShiftN;
  logic       busy, done, err;

  int total = 0;
  int bad = 0;

  shift_seq_ctrl #(.LUI_AMT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .shamt(shamt), .rs_amt(rs_amt),
    .EntryCtrl(EntryCtrl), .ShiftCtrl(ShiftCtrl), .ShiftN(ShiftN),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic out_t o(input logic [1:0] e, input logic [2:0] c, input logic [4:0] n,
                             input logic b, input logic d, input logic r);
    out_t t;
    t.entry = e; t.ctrl = c; t.n = n; t.busy = b; t.done = d; t.err = r;
    return t;
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = {EntryCtrl, ShiftCtrl, ShiftN, busy, done, err};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got entry=%b ctrl=%b n=%0d busy=%b done=%b err=%b, want entry=%b ctrl=%b n=%0d busy=%b done=%b err=%b",
               name, $time, act.entry, act.ctrl, act.n, act.busy, act.done, act.err,
               exp.entry, exp.ctrl, exp.n, exp.busy, exp.done, exp.err);
    end
  endtask

  task automatic drive(input logic s, input logic [2:0] o_, input logic [4:0] sh, input logic [4:0] rs);
    start = s; op = o_; shamt = sh; rs_amt = rs;
  endtask

  // Reference model: an accepted request expands into the list of cycles it will show.
  out_t cur;
  out_t q[$];

  function automatic void model_step(input logic s, input logic [2:0] o_, input logic [4:0] sh,
                                     input logic [4:0] rs);
    logic [2:0] cmd;
    logic [4:0] amt;
    logic [1:0] sel;
    if (!cur.busy && q.size() == 0 && s) begin
      if (o_ == 3'd7) begin
        q.push_back(o(2'b00, 3'b000, 5'd0, 1'b0, 1'b0, 1'b1));
      end else begin
        if (o_ == 3'd0 || o_ == 3'd3 || o_ == 3'd6) cmd = 3'b010;
        else if (o_ == 3'd1 || o_ == 3'd4)        cmd = 3'b011;
        else                                       cmd = 3'b100;
        if (o_ < 3'd3)       amt = sh;
        else if (o_ < 3'd6)  amt = rs;
        else                 amt = 5'd16;
        sel = (o_ == 3'd6) ? 2'b00 : 2'b01;
        q.push_back(o(sel, 3'b001, 5'd0, 1'b1, 1'b0, 1'b0));
        if (amt != 0) q.push_back(o(2'b00, cmd, amt, 1'b1, 1'b0, 1'b0));
        q.push_back(o(2'b00, 3'b000, 5'd0, 1'b1, 1'b1, 1'b0));
      end
    end
    cur = (q.size() != 0) ? q.pop_front() : o(2'b00, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  localparam int NV = 25;
  vec_t vecs[NV];
  out_t idle_o, ld_b, ld_ir, dn_o;

  initial begin
    idle_o = o(2'b00, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
    ld_b   = o(2'b01, 3'b001, 5'd0, 1'b1, 1'b0, 1'b0);
    ld_ir  = o(2'b00, 3'b001, 5'd0, 1'b1, 1'b0, 1'b0);
    dn_o   = o(2'b00, 3'b000, 5'd0, 1'b1, 1'b1, 1'b0);

    vecs[0]  = '{1'b1, 3'd0, 5'd3,  5'd9,  ld_b};
    vecs[1]  = '{1'b0, 3'd5, 5'd0,  5'd0,  o(2'b00, 3'b010, 5'd3, 1'b1, 1'b0, 1'b0)};
    vecs[2]  = '{1'b0, 3'd5, 5'd0,  5'd0,  dn_o};
    vecs[3]  = '{1'b0, 3'd0, 5'd0,  5'd0,  idle_o};
    vecs[4]  = '{1'b1, 3'd5, 5'd7,  5'd31, ld_b};
    vecs[5]  = '{1'b0, 3'd0, 5'd1,  5'd1,  o(2'b00, 3'b100, 5'd31, 1'b1, 1'b0, 1'b0)};
    vecs[6]  = '{1'b0, 3'd0, 5'd0,  5'd0,  dn_o};
    vecs[7]  = '{1'b0, 3'd0, 5'd0,  5'd0,  idle_o};
    vecs[8]  = '{1'b1, 3'd6, 5'd1,  5'd2,  ld_ir};
    vecs[9]  = '{1'b0, 3'd6, 5'd0,  5'd0,  o(2'b00, 3'b010, 5'd16, 1'b1, 1'b0, 1'b0)};
    vecs[10] = '{1'b0, 3'd0, 5'd0,  5'd0,  dn_o};
    vecs[11] = '{1'b0, 3'd0, 5'd0,  5'd0,  idle_o};
    vecs[12] = '{1'b1, 3'd1, 5'd0,  5'd12, ld_b};
    vecs[13] = '{1'b0, 3'd1, 5'd0,  5'd0,  dn_o};
    vecs[14] = '{1'b0, 3'd0, 5'd0,  5'd0,  idle_o};
    vecs[15] = '{1'b1, 3'd7, 5'd4,  5'd4,  o(2'b00, 3'b000, 5'd0, 1'b0, 1'b0, 1'b1)};
    vecs[16] = '{1'b0, 3'd7, 5'd0,  5'd0,  idle_o};
    vecs[17] = '{1'b1, 3'd0, 5'd2,  5'd0,  ld_b};
    vecs[18] = '{1'b1, 3'd0, 5'd2,  5'd0,  o(2'b00, 3'b010, 5'd2, 1'b1, 1'b0, 1'b0)};
    vecs[19] = '{1'b1, 3'd0, 5'd2,  5'd0,  dn_o};
    vecs[20] = '{1'b1, 3'd0, 5'd2,  5'd0,  idle_o};
    vecs[21] = '{1'b1, 3'd0, 5'd2,  5'd0,  ld_b};
    vecs[22] = '{1'b0, 3'd0, 5'd2,  5'd0,  o(2'b00, 3'b010, 5'd2, 1'b1, 1'b0, 1'b0)};
    vecs[23] = '{1'b0, 3'd0, 5'd0,  5'd0,  dn_o};
    vecs[24] = '{1'b0, 3'd0, 5'd0,  5'd0,  idle_o};

    // Reset state
    #1 check("reset_state", idle_o);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", idle_o);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].st, vecs[i].op, vecs[i].sh, vecs[i].rs);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Reset abort during SHIFT, then a clean request.
    drive(1'b1, 3'd0, 5'd4, 5'd0);
    @(posedge clk); #1; check("abort_load", ld_b);
    drive(1'b0, 3'd0, 5'd0, 5'd0);
    @(posedge clk); #1; check("abort_shift", o(2'b00, 3'b010, 5'd4, 1'b1, 1'b0, 1'b0));
    reset = 1'b0;
    #1 check("abort_async_zero", idle_o);
    @(posedge clk); #1; check("abort_held", idle_o);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1; check("abort_no_done", idle_o);
    drive(1'b1, 3'd2, 5'd5, 5'd0);
    @(posedge clk); #1; check("post_abort_load", ld_b);
    drive(1'b0, 3'd0, 5'd0, 5'd0);
    @(posedge clk); #1; check("post_abort_shift", o(2'b00, 3'b100, 5'd5, 1'b1, 1'b0, 1'b0));
    @(posedge clk); #1; check("post_abort_done", dn_o);
    @(posedge clk); #1; check("post_abort_idle", idle_o);

    // Randomized traffic
    cur = idle_o;
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      logic s;
      logic [2:0] ro;
      logic [4:0] rsh, rrs;
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b0;
        #1 check("rand_reset", idle_o);
        q.delete();
        cur = idle_o;
        @(negedge clk) reset = 1'b1;
      end
      s   = ($urandom_range(0, 2) != 0);
      ro  = 3'($urandom_range(0, 7));
      rsh = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      rrs = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      drive(s, ro, rsh, rrs);
      model_step(s, ro, rsh, rrs);
      @(posedge clk); #1;
      check("rand", cur);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
